sm3_msg_loader: RTL
===================

# sm3_msg_loader

Streaming front-end for the SM3 hash core. Accepts a message as 32-bit big-endian words over a valid/ready handshake and assembles them into the five 512-bit group buses plus the bit length `l`. It then issues a single-cycle `start` to `sm3_top` and holds all outputs stable until the core reports `valid`. It removes the need for the host to present 2560 bits and a length in one cycle.

## Interface

Parameters:
- `MAX_GROUPS`, default 5: groups buffered. Legal range 1..5. Capacity is `16*MAX_GROUPS` words. Group buses above `MAX_GROUPS` are tied to zero.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_data`  in  32  message word; first byte in bits [31:24].
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  final word of the message.
- `in_bytes`  in  2  valid bytes in the last word (1..3; 0 means 4). Ignored unless `in_last` is high.
- `in_ready`  out  1  loader can accept a word.
- `datain1`..`datain5`  out  512 each  group buses to `sm3_top`.
- `l`  out  32  message length in bits.
- `start`  out  1  single-cycle request to `sm3_top`.
- `hash_valid`  in  1  `valid` from `sm3_top`.
- `busy`  out  1  a message is in flight: high in FIRE and WAIT.
- `err`  out  1  sticky overflow flag.

## Operation

- Word accept condition: `in_valid && in_ready`.
- Placement of word index w (0-based): group `w/16`, bits `[511-32*(w%16) -: 32]`.
- Word counter is 7 bits wide.
- Length: `l = 32*(n-1) + 8*B`, where n is the number of words and B is `in_bytes`, with 0 mapped to 4. Computed when the last word is accepted. Maximum `l` is 2560.
- FSM states: IDLE, LOAD, DRAIN, FIRE, WAIT.
  - IDLE: `in_ready`=1. An accepted word stores at w=0 and clears `err`. The next state is FIRE if `in_last` is high, otherwise LOAD.
  - LOAD: `in_ready`=1. Words are stored at successive indices.
    - Accepted `in_last` goes to FIRE.
    - A word accepted without `in_last` when the counter already equals capacity goes to DRAIN, sets `err`, and is not stored.
  - DRAIN: `in_ready`=1. Words are discarded. Accepted `in_last` returns to IDLE with no `start`.
  - FIRE: `in_ready`=0. `start`=1 for exactly this one cycle, then go to WAIT.
  - WAIT: `in_ready`=0. `datain*` and `l` are held. When `hash_valid` is sampled high, go to IDLE.
- `hash_valid` outside WAIT is ignored.
- Empty messages cannot be expressed. The minimum message is one word with `in_last` high.
- Reset (any state, including mid-load or WAIT) forces the following:
  - State returns to IDLE.
  - `in_ready`=0 during reset, then 1 on the first cycle after.
  - `start`, `busy`, `err`, `l`, and all `datain*` are reset to 0.
  - The word counter is reset to 0.

## Timing

- Throughput: one word per cycle while `in_ready` is high. No combinational path from `in_valid` to `in_ready`.
- Last word accepted in cycle t:
  - `start`=1 and `busy`=1 in cycle t+1.
  - `datain*` and `l` are valid from t+1 until the loader leaves WAIT.
- `sm3_top` samples data in its IDLE state in the same cycle as `start`. The buses are therefore already final when `start` rises.
- `hash_valid` sampled high in cycle u gives `in_ready`=1 and `busy`=0 in cycle u+1.
- Simultaneous `in_valid` and `hash_valid` in WAIT: the word is not accepted because `in_ready`=0.
- `err` sets in the cycle after the overflow word and holds until the next message's first word is accepted.

## Configuration

`SM3_LOADER_ZEROFILL_EN`:
- Defined:
  - On acceptance of a message's first word, all group registers are cleared to zero before that word is stored.
  - In the last word, bytes beyond `in_bytes` are masked to zero.
  - Result: every bit at or above `l` is zero at `start`.
- Undefined:
  - No clearing or masking. Bits at or above `l` hold stale data; the downstream padding ignores bits at or above `l`.
  - Saves the 2560-bit clear multiplexer.

## Structure

- Shared package `sm3_pkg`:
  - `SM3_GROUP_W`=512.
  - `SM3_WORDS_PER_GROUP`=16.
  - `SM3_MAX_GROUPS`=5.
  - FSM state enum.
  - IV constants, shared with the core.
- Sub-module `sm3_len_calc`: combinational computation of `l` from word count and `in_bytes`. It is natural to split out and unit-test.
- The rest is a single module.

## Test plan

- "abc" vector: one word 0x61626300 with `in_last`=1, `in_bytes`=3.
  - Expect `l`=24 and `datain1[511:480]`=0x61626300.
  - `start` pulses one cycle at t+1; `datain2`..`datain5` are 0 (ZEROFILL).
  - After `hash_valid`, `in_ready`=1 next cycle.
- 16 words of 0x61626364, last with `in_bytes`=0.
  - Expect `l`=512, `datain1`={16{0x61626364}}, `datain2`=0.
- 80 words with values 0..79: expect `l`=2560, `datain5[31:0]`=79, `datain1[511:480]`=0.
- 81 words without `in_last`, then a final word with `in_last`.
  - Expect `err`=1 and no `start`; the loader returns to IDLE.
  - The next message clears `err` on its first accepted word.
- Backpressure and stalls:
  - `in_valid` toggled randomly during LOAD: stored words remain contiguous.
  - `in_valid` high throughout WAIT: no word accepted until `hash_valid`.
- Reset asserted during LOAD after 5 words:
  - All outputs are 0 during reset.
  - A subsequent 1-word message yields `l` set from that word only.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared SM3 constants, loader FSM states and the IV used by the core.
// Common to sm3_msg_loader, sm3_len_calc and sm3_top.
package sm3_pkg;

  localparam int SM3_GROUP_W         = 512;
  localparam int SM3_WORDS_PER_GROUP = 16;
  localparam int SM3_MAX_GROUPS      = 5;

  localparam logic [255:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FIRE,
    ST_WAIT
  } ld_state_t;

endpackage

// File: rtl/sm3_len_calc.sv
// Message bit length from the index of the last word and its byte count.
// l = 32*widx + 8*B, B = nbytes with 0 meaning a full word.
module sm3_len_calc (
  input  logic [6:0]  widx,
  input  logic [1:0]  nbytes,
  output logic [31:0] len
);

  logic [5:0] tail;

  // full words ahead of the last one plus the bytes used in it
  always_comb begin
    tail = (nbytes == 2'd0) ? 6'd32 : {1'b0, nbytes, 3'b000};
    len  = {20'd0, widx, 5'd0} + {26'd0, tail};
  end

endmodule

// File: rtl/sm3_msg_loader.sv
// Streams 32-bit big-endian words into the SM3 group buses and fires sm3_top.
// Optional SM3_LOADER_ZEROFILL_EN clears the buffer per message and masks the tail.
module sm3_msg_loader
  import sm3_pkg::*;
#(
  parameter int MAX_GROUPS = SM3_MAX_GROUPS
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] datain1,
  output logic [511:0] datain2,
  output logic [511:0] datain3,
  output logic [511:0] datain4,
  output logic [511:0] datain5,
  output logic [31:0]  l,
  output logic         start,
  input  logic         hash_valid,
  output logic         busy,
  output logic         err
);

  localparam int BUF_W = SM3_GROUP_W * SM3_MAX_GROUPS;
  localparam int CAP   = SM3_WORDS_PER_GROUP * MAX_GROUPS;
  localparam logic [6:0]  CAP7  = 7'(CAP);
  localparam logic [11:0] TOP_W = 12'(BUF_W - 32);

  ld_state_t        st_q;
  logic [6:0]       cnt_q;
  logic [BUF_W-1:0] buf_q;
  logic [31:0]      l_q;
  logic             rdy_q;
  logic             start_q;
  logic             busy_q;
  logic             err_q;

  logic             acc;
  logic [6:0]       widx;
  logic [11:0]      wbase;
  logic [31:0]      wdata;
  logic [31:0]      l_nxt;

  assign acc   = in_valid && rdy_q;
  assign widx  = (st_q == ST_IDLE) ? 7'd0 : cnt_q;
  assign wbase = TOP_W - {widx, 5'd0};

`ifdef SM3_LOADER_ZEROFILL_EN
  // keep only the valid leading bytes of the final word
  always_comb begin
    wdata = in_data;
    if (in_last) begin
      unique case (in_bytes)
        2'd1:    wdata[23:0] = '0;
        2'd2:    wdata[15:0] = '0;
        2'd3:    wdata[7:0]  = '0;
        default: wdata       = in_data;
      endcase
    end
  end
`else
  assign wdata = in_data;
`endif

  sm3_len_calc u_len (
    .widx   (widx),
    .nbytes (in_bytes),
    .len    (l_nxt)
  );

  // message FSM with registered handshake, strobe and data outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      l_q     <= '0;
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (acc) begin
            err_q <= 1'b0;
`ifdef SM3_LOADER_ZEROFILL_EN
            buf_q <= '0;
`endif
            buf_q[wbase +: 32] <= wdata;
            cnt_q <= 7'd1;
            if (in_last) begin
              l_q     <= l_nxt;
              st_q    <= ST_FIRE;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              rdy_q   <= 1'b0;
            end else begin
              st_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (acc) begin
            if (cnt_q == CAP7) begin
              // buffer full: a closing word aborts, else drain the rest
              err_q <= 1'b1;
              st_q  <= in_last ? ST_IDLE : ST_DRAIN;
            end else begin
              buf_q[wbase +: 32] <= wdata;
              cnt_q <= cnt_q + 7'd1;
              if (in_last) begin
                l_q     <= l_nxt;
                st_q    <= ST_FIRE;
                start_q <= 1'b1;
                busy_q  <= 1'b1;
                rdy_q   <= 1'b0;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (acc && in_last) st_q <= ST_IDLE;
        end
        ST_FIRE: begin
          st_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (hash_valid) begin
            st_q   <= ST_IDLE;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign start    = start_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign l        = l_q;

  assign datain1 = buf_q[BUF_W-1 -: 512];
  assign datain2 = (MAX_GROUPS > 1) ? buf_q[BUF_W-513  -: 512] : '0;
  assign datain3 = (MAX_GROUPS > 2) ? buf_q[BUF_W-1025 -: 512] : '0;
  assign datain4 = (MAX_GROUPS > 3) ? buf_q[BUF_W-1537 -: 512] : '0;
  assign datain5 = (MAX_GROUPS > 4) ? buf_q[BUF_W-2049 -: 512] : '0;

endmodule
